vga_write_arbiter: RTL and testbench

- Shares the single VGA adapter write port (x, y, colour, plot) between N independent drawing engines: ball, bat, flying ball, and score/screen painters.
- Uses round-robin, burst-granular arbitration. A granted engine owns the port until it signals its last pixel or drops its request.
- Sits between the drawing datapaths and the VGA adapter. The game control FSM keeps sequencing the engines; this block removes the per-engine muxing and write collisions.

---
 rtl/vga_write_arbiter_pkg.sv | 23 ++
 rtl/vga_write_arbiter_rr_picker.sv | 35 +++
 rtl/vga_write_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_write_arbiter_pkg.sv
// Shared constants for the VGA drawing path: screen geometry, default field widths,
// arbiter state encodings and the colour palette used by the drawing engines.
package vga_pkg;

    localparam int unsigned X_W_DEF  = 8;
    localparam int unsigned Y_W_DEF  = 7;
    localparam int unsigned C_W_DEF  = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT   = 2'b01;
    localparam logic [1:0] RELEASE = 2'b10;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;

endpackage

// File: rtl/vga_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping,
// returned one-hot together with a valid flag.
module rr_picker
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    int unsigned idx;
    logic        hit;

    always_comb begin
        win_o = '0;
        hit   = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!hit && req_i[idx]) begin
                win_o[idx] = 1'b1;
                hit        = 1'b1;
            end
        end
        valid_o = hit;
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Burst-granular round-robin owner of the single VGA adapter write port, shared by
// the ball, bat, flying-ball and screen/score drawing engines.
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned Y_W      = Y_W_DEF,
    parameter int unsigned C_W      = C_W_DEF,
    parameter int unsigned MAX_HOLD = 19200
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     pix_valid,
    input  logic [N_REQ-1:0]     pix_last,
    input  logic [N_REQ*X_W-1:0] pix_x,
    input  logic [N_REQ*Y_W-1:0] pix_y,
    input  logic [N_REQ*C_W-1:0] pix_colour,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [C_W-1:0]       vga_colour,
    output logic                 vga_plot,
    output logic                 timeout_err
);

    localparam int unsigned SEL_W  = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [X_W-1:0]    vga_x_q, vga_x_d;
    logic [Y_W-1:0]    vga_y_q, vga_y_d;
    logic [C_W-1:0]    vga_colour_q, vga_colour_d;
    logic              vga_plot_q, vga_plot_d;
    logic              timeout_q, timeout_d;

    logic [N_REQ-1:0]  win;
    logic              win_valid;
    logic [SEL_W-1:0]  win_idx;
    logic              req_sel, valid_sel, last_sel;
    logic [X_W-1:0]    x_sel;
    logic [Y_W-1:0]    y_sel;
    logic [C_W-1:0]    c_sel;
    logic              fire, hit_max;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (SEL_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    // Only the granted engine's slice is ever visible to the output registers.
    always_comb begin
        win_idx   = '0;
        req_sel   = 1'b0;
        valid_sel = 1'b0;
        last_sel  = 1'b0;
        x_sel     = '0;
        y_sel     = '0;
        c_sel     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx = SEL_W'(i);
            end
            if (sel_q == SEL_W'(i)) begin
                req_sel   = req[i];
                valid_sel = pix_valid[i];
                last_sel  = pix_last[i];
                x_sel     = pix_x[i*X_W +: X_W];
                y_sel     = pix_y[i*Y_W +: Y_W];
                c_sel     = pix_colour[i*C_W +: C_W];
            end
        end
    end

    assign fire    = req_sel & valid_sel;
    assign hit_max = (hold_q == HOLD_LAST);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        hold_d       = hold_q;
        gnt_d        = gnt_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    sel_d   = win_idx;
                    gnt_d   = win;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (fire) begin
                    vga_x_d      = x_sel;
                    vga_y_d      = y_sel;
                    vga_colour_d = c_sel;
                    vga_plot_d   = 1'b1;
                end
                // The watchdog is checked independently so it still pulses when a
                // last pixel or a dropped request coincides with the hold limit.
                if ((fire && last_sel) || !req_sel || hit_max) begin
                    gnt_d     = '0;
                    timeout_d = hit_max;
                    state_d   = RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE: begin
                rr_ptr_d = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            hold_q       <= '0;
            gnt_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_q       <= hold_d;
            gnt_q        <= gnt_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench: behavioural engines drive the arbiter, a transaction-level model
// predicts grants and plotted pixels, and a monitor compares them each cycle.
module tb_vga_write_arbiter;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int MH = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req, pix_valid, pix_last;
    logic [N*XW-1:0] pix_x;
    logic [N*YW-1:0] pix_y;
    logic [N*CW-1:0] pix_colour;
    logic [N-1:0]    gnt;
    logic            busy, vga_plot, timeout_err;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;

    vga_write_arbiter #(
        .N_REQ    (N),
        .X_W      (XW),
        .Y_W      (YW),
        .C_W      (CW),
        .MAX_HOLD (MH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .pix_valid   (pix_valid),
        .pix_last    (pix_last),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .gnt         (gnt),
        .busy        (busy),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [N-1:0]  gnt;
        logic          busy;
        logic          to;
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
    } ctrl_t;

    typedef struct {
        int            c;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
    } pix_t;

    ctrl_t ctrl_q[$];
    pix_t  pix_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Reference model: who owns the port, whether a release gap is pending,
    // the round-robin start point and how many cycles the owner has held it.
    int            m_owner = -1;
    bit            m_gap   = 1'b0;
    int            m_ptr   = 0;
    int            m_beats = 0;
    logic [XW-1:0] mx = '0;
    logic [YW-1:0] my = '0;
    logic [CW-1:0] mc = '0;

    // Engine behaviour
    bit e_act[N];
    int e_left[N], e_sent[N], e_len[N], e_drop[N], e_bursts[N];
    bit e_nolast[N];
    int e_bx[N], e_by[N], e_bc[N];
    bit rst_now;

    task automatic model_step();
        ctrl_t e;
        pix_t  p;
        int    w, o, idx;
        bit    fire, to;
        e.to   = 1'b0;
        e.plot = 1'b0;
        e.gnt  = '0;
        e.busy = 1'b0;
        if (reset) begin
            m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_beats = 0;
            mx = '0; my = '0; mc = '0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
            if (w >= 0) begin
                m_owner = w; m_beats = 0;
                e.gnt[w] = 1'b1; e.busy = 1'b1;
            end
        end else begin
            o    = m_owner;
            fire = req[o] && pix_valid[o];
            to   = (m_beats == MH - 1);
            if (fire) begin
                mx = pix_x[o*XW +: XW]; my = pix_y[o*YW +: YW]; mc = pix_colour[o*CW +: CW];
                p.c = cyc + 1; p.x = mx; p.y = my; p.col = mc;
                pix_q.push_back(p);
                e.plot = 1'b1;
            end
            if ((fire && pix_last[o]) || !req[o] || to) begin
                m_gap = 1'b1; m_ptr = (o + 1) % N; m_owner = -1;
            end else begin
                m_beats++;
                e.gnt[o] = 1'b1;
            end
            e.busy = 1'b1;
            e.to   = to;
        end
        e.c = cyc + 1; e.x = mx; e.y = my; e.col = mc;
        ctrl_q.push_back(e);
    endtask

    task automatic drive_step();
        logic [N-1:0] g;
        bit r, v, l, fin;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        g = gnt;
        for (int i = 0; i < N; i++) begin
            x = XW'($urandom); y = YW'($urandom); c = CW'($urandom);
            l = 1'b0;
            fin = e_act[i] && (e_left[i] == 0);
            if (fin) e_act[i] = 1'b0;
            if (!e_act[i] && e_bursts[i] > 0 && !(fin && g[i] === 1'b1)) begin
                e_bursts[i]--; e_act[i] = 1'b1; e_left[i] = e_len[i]; e_sent[i] = 0;
            end
            r = e_act[i];
            v = 1'b0;
            if (e_act[i] && g[i] === 1'b1) begin
                x = XW'(e_bx[i] + e_sent[i]); y = YW'(e_by[i]); c = CW'(e_bc[i]);
                if (e_sent[i] == e_drop[i]) begin
                    r = 1'b0; v = 1'b1; e_act[i] = 1'b0; e_left[i] = 0;
                end else if ($urandom_range(0, 99) < 85) begin
                    v = 1'b1;
                    l = !e_nolast[i] && (e_left[i] == 1);
                    e_left[i]--; e_sent[i]++;
                end
            end else begin
                v = ($urandom_range(0, 3) == 0);
                l = 1'($urandom_range(0, 1));
            end
            req[i] = r; pix_valid[i] = v; pix_last[i] = l;
            pix_x[i*XW +: XW] = x; pix_y[i*YW +: YW] = y; pix_colour[i*CW +: CW] = c;
        end
    endtask

    task automatic step();
        reset = rst_now;
        drive_step();
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
            step();
        end
    endtask

    task automatic burst(input int i, input int len, input int drop, input bit nolast,
                         input int bx, input int by, input int bc, input int nb);
        e_len[i] = len; e_drop[i] = drop; e_nolast[i] = nolast;
        e_bx[i] = bx; e_by[i] = by; e_bc[i] = bc;
        e_bursts[i] += nb;
    endtask

    task automatic clear_engines();
        for (int i = 0; i < N; i++) begin
            e_act[i] = 1'b0; e_left[i] = 0; e_sent[i] = 0; e_bursts[i] = 0; e_drop[i] = -1;
        end
    endtask

    // Monitor
    initial begin
        ctrl_t e;
        pix_t  p;
        forever begin
            @(negedge clock);
            if (ctrl_q.size() > 0 && ctrl_q[0].c == cyc) begin
                e = ctrl_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("timeout_err", 32'(timeout_err), 32'(e.to));
                chk("vga_plot", 32'(vga_plot), 32'(e.plot));
                chk("vga_x_held", 32'(vga_x), 32'(e.x));
                chk("vga_y_held", 32'(vga_y), 32'(e.y));
                chk("vga_colour_held", 32'(vga_colour), 32'(e.col));
            end
            if (pix_q.size() > 0 && pix_q[0].c == cyc) begin
                p = pix_q.pop_front();
                chk("pixel_plotted", 32'(vga_plot), 32'd1);
                chk("pixel_x", 32'(vga_x), 32'(p.x));
                chk("pixel_y", 32'(vga_y), 32'(p.y));
                chk("pixel_colour", 32'(vga_colour), 32'(p.col));
            end else if (vga_plot === 1'b1) begin
                chk("pixel_spurious", 32'(vga_plot), 32'd0);
            end
        end
    end

    // Stimulus
    initial begin
        clear_engines();
        req = '0; pix_valid = '0; pix_last = '0; pix_x = '0; pix_y = '0; pix_colour = '0;
        rst_now = 1'b1;
        step();
        run(2);
        rst_now = 1'b0;

        // single request, engine 1, pixels (5,7,3),(6,7,3)
        burst(1, 2, -1, 1'b0, 5, 7, 3, 1);
        run(10);

        // contention from rr_ptr=0: order 0,1,3
        rst_now = 1'b1; run(1); rst_now = 1'b0;
        burst(0, 3, -1, 1'b0, 16, 10, 1, 1);
        burst(1, 3, -1, 1'b0, 48, 20, 2, 1);
        burst(3, 3, -1, 1'b0, 96, 40, 4, 1);
        run(30);

        // engine 2 drops its request while offering pixel 4
        burst(2, 6, 4, 1'b0, 120, 60, 5, 1);
        run(20);

        // watchdog: engine 0 streams with no last pixel, engine 1 waits
        burst(0, 24, -1, 1'b1, 0, 1, 6, 1);
        run(3);
        burst(1, 3, -1, 1'b0, 140, 100, 7, 1);
        run(50);

        // reset in the middle of a burst, then only engine 3 requests
        burst(2, 10, -1, 1'b0, 30, 30, 3, 1);
        run(5);
        rst_now = 1'b1; run(1); rst_now = 1'b0;
        clear_engines();
        burst(3, 2, -1, 1'b0, 150, 110, 2, 1);
        run(10);

        // engine 0 re-requests at its release while engine 2 waits
        burst(0, 3, -1, 1'b0, 10, 50, 1, 2);
        run(2);
        burst(2, 3, -1, 1'b0, 70, 90, 6, 1);
        run(30);

        // randomised traffic with occasional resets
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!e_act[i] && e_bursts[i] == 0 && $urandom_range(0, 99) < 4) begin
                    int len;
                    int drop;
                    len  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 6));
                    drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                    burst(i, len, drop, len == 20, int'($urandom_range(0, 159)),
                          int'($urandom_range(0, 119)), int'($urandom_range(0, 7)),
                          int'($urandom_range(1, 2)));
                end
            end
            rst_now = ($urandom_range(0, 999) == 0);
            run(1);
        end
        rst_now = 1'b0;
        run(200);
        clear_engines();
        run(10);
        chk("pixel_queue_drained", 32'(pix_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
